ps2_tecla_rx: RTL and testbench



---
 rtl/ps2_tecla_rx.sv | 129 ++++++++++++
 tb/tb_ps2_tecla_rx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ps2_tecla_rx.sv
// ps2_tecla_rx: PS/2 keyboard receiver that holds the last make code on tecla, ignoring break/extended sequences.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_tecla_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] tecla,
    output logic       tecla_tick,
    output logic       rx_done_tick,
    output logic       frame_err
);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, DPS, LOAD} state_t;
    state_t state, state_n;
    logic [1:0] c_sync, d_sync;
    logic [FILTER_LEN-1:0] filt;
    logic f_val, f_prev, fall, d_s;
    logic [3:0] n, n_n;
    logic [10:0] b, b_n;
    logic [WW-1:0] wd, wd_n;
    logic brk, ext, brk_n, ext_n, byte_ok;
    logic [7:0] tecla_n, data;

    assign fall = f_prev & ~f_val;
    assign d_s  = d_sync[1];
    assign data = b[8:1];
`ifdef PS2_PARITY_CHECK_EN
    assign byte_ok = b[10] & (^b[9:1]);
`else
    assign byte_ok = b[10];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
            filt   <= '1;
            f_val  <= 1'b1;
            f_prev <= 1'b1;
            state  <= IDLE;
            n      <= '0;
            b      <= '0;
            wd     <= '0;
            brk    <= 1'b0;
            ext    <= 1'b0;
            tecla  <= 8'h00;
        end else begin
            c_sync <= {c_sync[0], ps2c};
            d_sync <= {d_sync[0], ps2d};
            filt   <= {filt[FILTER_LEN-2:0], c_sync[1]};
            f_val  <= (&filt) ? 1'b1 : (~|filt) ? 1'b0 : f_val;
            f_prev <= f_val;
            state  <= state_n;
            n      <= n_n;
            b      <= b_n;
            wd     <= wd_n;
            brk    <= brk_n;
            ext    <= ext_n;
            tecla  <= tecla_n;
        end
    end

    always_comb begin
        state_n      = state;
        n_n          = n;
        b_n          = b;
        wd_n         = wd;
        brk_n        = brk;
        ext_n        = ext;
        tecla_n      = tecla;
        rx_done_tick = 1'b0;
        tecla_tick   = 1'b0;
        frame_err    = 1'b0;
        case (state)
            IDLE: begin
                if (fall && rx_en) begin
                    if (d_s) begin
                        frame_err = 1'b1;
                    end else begin
                        state_n = DPS;
                        n_n     = 4'd9;
                        wd_n    = '0;
                        b_n     = {d_s, b[10:1]};
                    end
                end
            end
            DPS: begin
                // timeout takes priority over a coincident edge
                if (wd == WW'(TIMEOUT_CYC - 1)) begin
                    frame_err = 1'b1;
                    state_n   = IDLE;
                    wd_n      = '0;
                end else if (fall) begin
                    b_n  = {d_s, b[10:1]};
                    wd_n = '0;
                    if (n == 4'd0) state_n = LOAD;
                    else n_n = n - 4'd1;
                end else begin
                    wd_n = wd + 1'b1;
                end
            end
            LOAD: begin
                state_n = IDLE;
                if (!byte_ok) begin
                    frame_err = 1'b1;
                end else begin
                    rx_done_tick = 1'b1;
                    if (data == 8'hF0) begin
                        brk_n = 1'b1;
                    end else if (data == 8'hE0) begin
                        ext_n = 1'b1;
                    end else if (brk || ext) begin
                        brk_n = 1'b0;
                        ext_n = 1'b0;
                    end else begin
                        tecla_n    = data;
                        tecla_tick = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ps2_tecla_rx.sv
// tb_ps2_tecla_rx: table-driven PS/2 frame vectors plus hand sequences for timeout, glitches, reset and rx_en.
module tb_ps2_tecla_rx;
    localparam int TO = 300;
    logic clk = 1'b0, reset = 1'b1, ps2c = 1'b1, ps2d = 1'b1, rx_en = 1'b1;
    logic [7:0] tecla;
    logic tecla_tick, rx_done_tick, frame_err;
    int checks = 0, failures = 0;
    int n_done = 0, n_tt = 0, n_err = 0, n_tt_alone = 0;

    ps2_tecla_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
        .tecla(tecla), .tecla_tick(tecla_tick), .rx_done_tick(rx_done_tick), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done_tick) n_done++;
        if (tecla_tick) n_tt++;
        if (frame_err) n_err++;
        if (tecla_tick && !rx_done_tick) n_tt_alone++;
    end

    typedef struct {
        logic [7:0] c0, c1, c2;
        int nc;
        bit bad_par;
        logic [7:0] e_tecla;
        int e_done, e_tt, e_err;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // nbits < 11 sends a truncated frame and leaves ps2c idle
    task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit glitch);
        logic [10:0] bits;
        bits = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            if (glitch) begin
                repeat (6) @(posedge clk);
                ps2c = 1'b0;
                repeat (2) @(posedge clk);
                ps2c = 1'b1;
                repeat (12) @(posedge clk);
            end else begin
                repeat (20) @(posedge clk);
            end
            ps2c = 1'b0;
            repeat (20) @(posedge clk);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    initial begin
        int d0, t0, e0;
        logic [7:0] codes[3];
        vecs[0] = '{8'h73, 8'h00, 8'h00, 1, 1'b0, 8'h73, 1, 1, 0};
        vecs[1] = '{8'h6C, 8'hF0, 8'h6C, 3, 1'b0, 8'h6C, 3, 1, 0};
        vecs[2] = '{8'hE0, 8'h70, 8'h00, 2, 1'b0, 8'h00, 2, 0, 0};
`ifdef PS2_PARITY_CHECK_EN
        vecs[3] = '{8'h7A, 8'h00, 8'h00, 1, 1'b1, 8'h00, 0, 0, 1};
`else
        vecs[3] = '{8'h7A, 8'h00, 8'h00, 1, 1'b1, 8'h7A, 1, 1, 0};
`endif
        vecs[4] = '{8'h1C, 8'h1C, 8'h00, 2, 1'b0, 8'h1C, 2, 2, 0};
        vecs[5] = '{8'hE0, 8'hF0, 8'h75, 3, 1'b0, 8'h00, 3, 0, 0};

        do_reset();
        @(negedge clk);
        chk("reset tecla", tecla, 8'h00);
        chk("reset tecla_tick", tecla_tick, 0);
        chk("reset rx_done_tick", rx_done_tick, 0);
        chk("reset frame_err", frame_err, 0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            d0 = n_done; t0 = n_tt; e0 = n_err;
            codes = '{vecs[v].c0, vecs[v].c1, vecs[v].c2};
            for (int j = 0; j < vecs[v].nc; j++) send_frame(codes[j], vecs[v].bad_par, 1'b0, 11, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d tecla", v), tecla, vecs[v].e_tecla);
            chk($sformatf("vec%0d done", v), n_done - d0, vecs[v].e_done);
            chk($sformatf("vec%0d tecla_tick", v), n_tt - t0, vecs[v].e_tt);
            chk($sformatf("vec%0d frame_err", v), n_err - e0, vecs[v].e_err);
        end

        // timeout after a partial frame, then recovery
        do_reset();
        d0 = n_done; e0 = n_err;
        send_frame(8'h55, 1'b0, 1'b0, 5, 1'b0);
        repeat (TO + 50) @(posedge clk);
        @(negedge clk);
        chk("timeout frame_err", n_err - e0, 1);
        chk("timeout done", n_done - d0, 0);
        send_frame(8'h21, 1'b0, 1'b0, 11, 1'b0);
        @(negedge clk);
        chk("after timeout tecla", tecla, 8'h21);
        chk("after timeout done", n_done - d0, 1);

        // short ps2c glitches must not add edges
        d0 = n_done; e0 = n_err;
        send_frame(8'h2D, 1'b0, 1'b0, 11, 1'b1);
        @(negedge clk);
        chk("glitch tecla", tecla, 8'h2D);
        chk("glitch done", n_done - d0, 1);
        chk("glitch frame_err", n_err - e0, 0);

        // bad stop bit
        d0 = n_done; e0 = n_err;
        send_frame(8'h44, 1'b0, 1'b1, 11, 1'b0);
        @(negedge clk);
        chk("bad stop frame_err", n_err - e0, 1);
        chk("bad stop done", n_done - d0, 0);
        chk("bad stop tecla", tecla, 8'h2D);

        // reset mid-frame discards the partial frame
        send_frame(8'h66, 1'b0, 1'b0, 5, 1'b0);
        d0 = n_done; t0 = n_tt; e0 = n_err;
        do_reset();
        repeat (TO + 50) @(posedge clk);
        @(negedge clk);
        chk("midreset tecla", tecla, 8'h00);
        chk("midreset ticks", (n_done - d0) + (n_tt - t0) + (n_err - e0), 0);
        send_frame(8'h33, 1'b0, 1'b0, 11, 1'b0);
        @(negedge clk);
        chk("after midreset tecla", tecla, 8'h33);

        // rx_en low blocks frame start
        d0 = n_done; e0 = n_err;
        rx_en = 1'b0;
        send_frame(8'h15, 1'b0, 1'b0, 11, 1'b0);
        rx_en = 1'b1;
        @(negedge clk);
        chk("rx_en blocked done", n_done - d0, 0);
        chk("rx_en blocked tecla", tecla, 8'h33);

        // rx_en dropped mid-frame: frame still completes
        d0 = n_done;
        fork
            send_frame(8'h4B, 1'b0, 1'b0, 11, 1'b0);
            begin
                repeat (60) @(posedge clk);
                rx_en = 1'b0;
            end
        join
        rx_en = 1'b1;
        @(negedge clk);
        chk("rx_en midframe tecla", tecla, 8'h4B);
        chk("rx_en midframe done", n_done - d0, 1);

        chk("tecla_tick without rx_done", n_tt_alone, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
